sort_checker: RTL
=================

// Module: sort_checker
// PURPOSE
//  Avalon-ST sink that receives packets from the sorting block's source port.
//  Checks framing, non-decreasing data order and packet length; reports per-packet status.
//  Sits at the sorter output in the sort subsystem and in its verification harness.
//  stall_i applies backpressure to exercise src_ready_i of the upstream sorter.
// PARAMETERS
//  DWIDTH       8    data word width, compared unsigned
//  MAX_PKT_LEN  256  max legal beats per packet; LW = $clog2(MAX_PKT_LEN)+1
// PORTS
//  clk_i                in  1       single clock, all logic on posedge
//  srst_i               in  1       reset: synchronous, active-high
//  snk_data_i           in  DWIDTH  beat data
//  snk_startofpacket_i  in  1       first beat of packet
//  snk_endofpacket_i    in  1       last beat of packet
//  snk_valid_i          in  1       beat valid
//  snk_ready_o          out 1       sink ready
//  stall_i              in  1       1 = deassert ready (backpressure)
//  pkt_done_o           out 1       one-cycle pulse, status outputs updated
//  pkt_len_o            out LW      beats in last packet, saturates at MAX_PKT_LEN
//  pkt_min_o            out DWIDTH  first beat of last packet
//  pkt_max_o            out DWIDTH  last beat of last packet
//  sort_err_o           out 1       last packet had beat[i] < beat[i-1]
//  frame_err_o          out 1       last packet had a stray or missing sop
//  len_err_o            out 1       last packet longer than MAX_PKT_LEN
//  pkt_cnt_o            out 32      packets reported, wraps
//  err_cnt_o            out 16      packets with any error, saturates at 16'hFFFF
// BEHAVIOUR
//  - Transfer = snk_valid_i & snk_ready_o. Data, sop and eop are ignored when there is no transfer.
//  - snk_ready_o = !srst_i & !stall_i & (state != REPORT_S). Combinational, no dependency on valid.
//  - Reset: state IDLE_S; all outputs and counters 0; snk_ready_o 0 while srst_i=1.
//  - Reset mid-packet: the partial packet is discarded, with no pulse and no counter update.
//  - FSM IDLE_S -> RECV_S -> REPORT_S -> IDLE_S.
//  - IDLE_S, transfer with sop:
//    - len=1, prev=data, first=data, errors cleared.
//    - If eop is also set (one-beat packet), go to REPORT_S; otherwise go to RECV_S.
//  - IDLE_S, transfer without sop:
//    - Beat is dropped, frame_err=1, len=0, go to REPORT_S.
//  - RECV_S, each transfer:
//    - data<prev sets sort_err; data==prev is legal.
//    - sop=1 sets frame_err; the beat still counts as data.
//    - len increments; at MAX_PKT_LEN it holds and len_err is set.
//    - prev <= data.
//    - eop=1 goes to REPORT_S.
//  - REPORT_S lasts exactly one cycle, then returns to IDLE_S:
//    - pkt_done_o=1.
//    - Status outputs load from the internal registers.
//    - pkt_cnt_o increments.
//    - err_cnt_o increments if any error flag is set.
//  - Latency: eop accepted in cycle N -> pkt_done_o and new status in cycle N+1.
//    The next packet can be accepted from cycle N+2.
//  - Status outputs hold their value between pulses.
//  - pkt_max_o is the last beat, which is the maximum only when sort_err_o=0.
//  - stall_i may toggle every cycle. A beat stalled mid-packet is neither lost nor duplicated.
// TESTING
//  1. Reset, then 4-beat packet 1,3,3,9 with stall_i=0:
//     -> pkt_done one cycle after eop; len=4, min=1, max=9; no errors; pkt_cnt=1.
//  2. Packet 5,2,7:
//     -> sort_err=1, len=3, err_cnt=1; following clean packet clears sort_err_o.
//  3. One-beat packet (sop&eop, data 8'hAA):
//     -> len=1, min=max=8'hAA, no errors.
//  4. Stray beat without sop in IDLE_S:
//     -> pkt_done with frame_err=1, len=0.
//     Then sop mid-packet in a 5-beat stream -> frame_err=1, len=5.
//  5. MAX_PKT_LEN+3 beats, ascending:
//     -> len_err=1, pkt_len_o=MAX_PKT_LEN.
//  6. Random stall_i (50%) over 100 random sorted packets:
//     -> pkt_cnt=100, err_cnt=0.
//     Then srst_i asserted mid-packet -> no pulse; counters and outputs read 0.

Source files
------------

// File: rtl/sort_checker.sv
// Avalon-ST sink at the sorter output: checks framing, non-decreasing order and
// packet length, and reports per-packet status with a one-cycle done pulse.
module sort_checker #(
    parameter int unsigned DWIDTH      = 8,
    parameter int unsigned MAX_PKT_LEN = 256,
    localparam int unsigned LW         = $clog2(MAX_PKT_LEN) + 1
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic [DWIDTH-1:0] snk_data_i,
    input  logic              snk_startofpacket_i,
    input  logic              snk_endofpacket_i,
    input  logic              snk_valid_i,
    output logic              snk_ready_o,
    input  logic              stall_i,
    output logic              pkt_done_o,
    output logic [LW-1:0]     pkt_len_o,
    output logic [DWIDTH-1:0] pkt_min_o,
    output logic [DWIDTH-1:0] pkt_max_o,
    output logic              sort_err_o,
    output logic              frame_err_o,
    output logic              len_err_o,
    output logic [31:0]       pkt_cnt_o,
    output logic [15:0]       err_cnt_o
);

    typedef enum logic [1:0] {IDLE_S, RECV_S, REPORT_S} state_t;

    state_t            state;
    logic              xfer;
    logic [LW-1:0]     len_q, len_d;
    logic [DWIDTH-1:0] prev_q, prev_d;
    logic [DWIDTH-1:0] first_q, first_d;
    logic              sort_err_q, sort_err_d;
    logic              frame_err_q, frame_err_d;
    logic              len_err_q, len_err_d;
    logic              report_d;

    assign snk_ready_o = !srst_i && !stall_i && (state != REPORT_S);
    assign xfer        = snk_valid_i && snk_ready_o;

    // Next values of the packet accumulators, so the report can load the status
    // registers on the same edge that accepts the eop beat.
    always_comb begin
        len_d       = len_q;
        prev_d      = prev_q;
        first_d     = first_q;
        sort_err_d  = sort_err_q;
        frame_err_d = frame_err_q;
        len_err_d   = len_err_q;
        report_d    = 1'b0;
        if (xfer) begin
            case (state)
                IDLE_S: begin
                    sort_err_d = 1'b0;
                    len_err_d  = 1'b0;
                    if (snk_startofpacket_i) begin
                        len_d       = LW'(1);
                        prev_d      = snk_data_i;
                        first_d     = snk_data_i;
                        frame_err_d = 1'b0;
                        report_d    = snk_endofpacket_i;
                    end else begin
                        len_d       = '0;
                        frame_err_d = 1'b1;
                        report_d    = 1'b1;
                    end
                end
                RECV_S: begin
                    if (snk_data_i < prev_q)
                        sort_err_d = 1'b1;
                    if (snk_startofpacket_i)
                        frame_err_d = 1'b1;
                    if (len_q == LW'(MAX_PKT_LEN))
                        len_err_d = 1'b1;
                    else
                        len_d = len_q + LW'(1);
                    prev_d   = snk_data_i;
                    report_d = snk_endofpacket_i;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state       <= IDLE_S;
            len_q       <= '0;
            prev_q      <= '0;
            first_q     <= '0;
            sort_err_q  <= 1'b0;
            frame_err_q <= 1'b0;
            len_err_q   <= 1'b0;
            pkt_done_o  <= 1'b0;
            pkt_len_o   <= '0;
            pkt_min_o   <= '0;
            pkt_max_o   <= '0;
            sort_err_o  <= 1'b0;
            frame_err_o <= 1'b0;
            len_err_o   <= 1'b0;
            pkt_cnt_o   <= '0;
            err_cnt_o   <= '0;
        end else begin
            len_q       <= len_d;
            prev_q      <= prev_d;
            first_q     <= first_d;
            sort_err_q  <= sort_err_d;
            frame_err_q <= frame_err_d;
            len_err_q   <= len_err_d;
            pkt_done_o  <= 1'b0;

            case (state)
                IDLE_S:   if (xfer) state <= report_d ? REPORT_S : RECV_S;
                RECV_S:   if (report_d) state <= REPORT_S;
                REPORT_S: state <= IDLE_S;
                default:  state <= IDLE_S;
            endcase

            if (report_d) begin
                pkt_done_o  <= 1'b1;
                pkt_len_o   <= len_d;
                pkt_min_o   <= first_d;
                pkt_max_o   <= prev_d;
                sort_err_o  <= sort_err_d;
                frame_err_o <= frame_err_d;
                len_err_o   <= len_err_d;
                pkt_cnt_o   <= pkt_cnt_o + 32'd1;
                if ((sort_err_d || frame_err_d || len_err_d) && (err_cnt_o != '1))
                    err_cnt_o <= err_cnt_o + 16'd1;
            end
        end
    end

endmodule
